aukv_imem_responder: RTL

- Instruction-memory responder: the slave end of the fetch-unit instruction bus (addr/addr_valid in, data/data_valid out).
- On-chip word-addressed RAM, fixed-latency pipelined read responses, one request accepted every cycle, no backpressure.
- Side write port for program load by the bootloader or debug.
- Post-reset INIT sequencer fills the RAM with the NOP word before serving requests.

---
 rtl/aukv_imem_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aukv_imem_responder.sv
// Instruction-memory responder: word-addressed RAM behind the fetch bus, fixed-latency reads,
// side load port, post-reset NOP fill. Define AUKV_IMEM_PARITY_EN for per-word even parity.
module aukv_imem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] INIT_WORD = 32'h0000_0033
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr_addr,
    input  logic        i_instr_addr_valid,
    output logic [31:0] o_instr_data,
    output logic        o_instr_data_valid,
    output logic        o_err,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_addr,
    input  logic [31:0] i_wr_data,
`ifdef AUKV_IMEM_PARITY_EN
    input  logic        i_par_inject,
`endif
    output logic        o_init_done
);

    // state   | meaning
    // ST_INIT | filling RAM with INIT_WORD, requests latched as pending, no responses
    // ST_RUN  | serving fetch requests and load-port writes until reset

    localparam int AW = $clog2(DEPTH);
`ifdef AUKV_IMEM_PARITY_EN
    localparam int MW = 33;
`else
    localparam int MW = 32;
`endif

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t         state;
    logic [AW-1:0]  fill_cnt;
    logic           pend_valid;
    logic [31:0]    pend_addr;
    logic           init_done;

    logic           issue;
    logic [31:0]    issue_addr;
    logic [31:0]    rd_off;
    logic [31:0]    wr_off;
    logic           rd_hit;
    logic           wr_hit;
    logic           mem_we;
    logic [AW-1:0]  mem_widx;
    logic [MW-1:0]  mem_wdata;
    logic [AW-1:0]  rd_idx;
    logic           unused_wr_lsb;

    logic [MW-1:0]  mem [DEPTH];
    logic [MW-1:0]  rd_word;
    logic           s1_valid;
    logic           s1_hit;
    logic [31:0]    s1_data;
    logic           s1_err;
    logic           par_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_INIT;
            fill_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (i_instr_addr_valid) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= i_instr_addr;
                    end
                    if (fill_cnt == AW'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pend_valid <= 1'b0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // A live request always beats the address parked during INIT.
    always_comb begin
        issue      = (state == ST_RUN) && (i_instr_addr_valid || pend_valid);
        issue_addr = i_instr_addr_valid ? i_instr_addr : pend_addr;
        rd_off     = issue_addr - BASE_ADDR;
        rd_hit     = (rd_off[1:0] == 2'b00) && ({2'b00, rd_off[31:2]} < DEPTH);
        rd_idx     = rd_off[AW+1:2];
        wr_off     = i_wr_addr - BASE_ADDR;
        wr_hit     = {2'b00, wr_off[31:2]} < DEPTH;
    end

    assign unused_wr_lsb = ^wr_off[1:0];

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = wr_off[AW+1:2];
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we          = 1'b1;
            mem_widx        = fill_cnt;
            mem_wdata[31:0] = INIT_WORD;
        end else begin
            mem_we          = i_wr_en && wr_hit;
            mem_wdata[31:0] = i_wr_data;
        end
`ifdef AUKV_IMEM_PARITY_EN
        mem_wdata[32] = ^mem_wdata[31:0] ^ ((state == ST_RUN) && i_par_inject);
`endif
    end

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[mem_widx] <= mem_wdata;
        rd_word <= mem[rd_idx];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_hit   <= rd_hit;
        end
    end

`ifdef AUKV_IMEM_PARITY_EN
    assign par_err = ^rd_word;
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        s1_data = (s1_valid && s1_hit) ? rd_word[31:0] : INIT_WORD;
        s1_err  = s1_valid && (!s1_hit || par_err);
    end

    generate
        if (LATENCY <= 1) begin : g_lat1
            assign o_instr_data       = s1_data;
            assign o_instr_data_valid = s1_valid;
            assign o_err              = s1_err;
        end else begin : g_latn
            logic [LATENCY-2:0] pv;
            logic [LATENCY-2:0] pe;
            logic [31:0]        pd [LATENCY-1];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    pv <= '0;
                    pe <= '0;
                    for (int i = 0; i < LATENCY - 1; i++)
                        pd[i] <= INIT_WORD;
                end else begin
                    pv[0] <= s1_valid;
                    pe[0] <= s1_err;
                    pd[0] <= s1_data;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pv[i] <= pv[i-1];
                        pe[i] <= pe[i-1];
                        pd[i] <= pd[i-1];
                    end
                end
            end

            assign o_instr_data       = pd[LATENCY-2];
            assign o_instr_data_valid = pv[LATENCY-2];
            assign o_err              = pe[LATENCY-2];
        end
    endgenerate

    assign o_init_done = init_done;

endmodule
